vga_vram_arbiter: RTL

Arbitrates a single-port, synchronous-read character VRAM between the VGA text-mode scan-out fetch and a CPU bus port. The display has strict priority, so character fetches are never delayed. CPU requests are held in a one-entry buffer until a free slot opens. The block sits between the VGA controller (character counters), the CPU MMIO bridge and the VRAM macro, and returns read data to each requester.

---
 rtl/vga_vram_arbiter_if.sv | 43 ++++
 rtl/vga_vram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VGA fetch, CPU MMIO bridge, VRAM macro and the arbiter.
// The arbiter takes the slave side; requesters and the VRAM model take the master side.
interface vga_vram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_valid, disp_data,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_valid, disp_data,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has strict priority, CPU waits in a one-entry buffer.
// Optional macro VGA_VRAM_ARB_RDHOLD_EN keeps cpu_rdata stable between CPU read returns.
module vga_vram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                pclk,
    input  logic                reset,
    vga_vram_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } req_state_t;

    req_state_t        state;
    req_state_t        state_next;

    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    logic              disp_grant;
    logic              cpu_grant;
    logic              capture;

    logic              tag1_valid;
    logic              tag1_cpu;
    logic              tag2_valid;
    logic              tag2_cpu;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Display always wins; the buffered CPU request only gets the cycles scan-out leaves idle.
    always_comb begin
        state_next = state;
        disp_grant = 1'b0;
        cpu_grant  = 1'b0;
        capture    = 1'b0;

        if (bus.disp_req) begin
            disp_grant = 1'b1;
        end else if (state == PEND) begin
            cpu_grant = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.cpu_valid) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (cpu_grant) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (capture) begin
            hold_we    <= bus.cpu_we;
            hold_addr  <= bus.cpu_addr;
            hold_wdata <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (disp_grant) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.disp_addr;
            mem_wdata_q <= '0;
        end else if (cpu_grant) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= hold_we;
            mem_addr_q  <= hold_addr;
            mem_wdata_q <= hold_wdata;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end
    end

    // Stage 1 lines up with the mem access, stage 2 with the VRAM's registered read data.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            tag1_valid <= 1'b0;
            tag1_cpu   <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_cpu   <= 1'b0;
        end else begin
            tag1_valid <= disp_grant | (cpu_grant & ~hold_we);
            tag1_cpu   <= cpu_grant;
            tag2_valid <= tag1_valid;
            tag2_cpu   <= tag1_cpu;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            disp_valid_q <= tag2_valid & ~tag2_cpu;
            if (tag2_valid && !tag2_cpu) begin
                disp_data_q <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= tag2_valid & tag2_cpu;
`ifdef VGA_VRAM_ARB_RDHOLD_EN
            if (tag2_valid && tag2_cpu) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
`else
            cpu_rdata_q <= (tag2_valid && tag2_cpu) ? bus.mem_rdata : '0;
`endif
        end
    end

    assign bus.cpu_ready  = (state == IDLE);
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;

endmodule
